spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arb_pkg.sv | 22 ++
 rtl/spi_arb_if.sv | 21 ++
 rtl/spi_arb_hold_reg.sv | 27 ++
 rtl/spi_arbiter.sv | 149 ++++++++++++++
 tb/tb_spi_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI byte arbiter.
// Holds FSM state codes, the hold-timeout default and the flush byte.
package spi_arb_pkg;

   localparam int HOLD_TIMEOUT_DEF = 255;
   localparam logic [7:0] FLUSH_BYTE = 8'h00;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_ISSUE = 3'd1;
   localparam state_t S_RUN   = 3'd2;
   localparam state_t S_HOLD  = 3'd3;
   localparam state_t S_FLUSH = 3'd4;

   typedef struct packed {
      logic [7:0] data;
      logic       dc;
      logic       end_txn;
   } hold_t;

endpackage

// File: rtl/spi_arb_if.sv
// Byte-level link between the arbiter (master) and the SPI controller (slave).
interface spi_arb_if;

   logic       spi_start;
   logic [7:0] spi_data;
   logic       spi_dc;
   logic       spi_end_txn;
   logic       spi_busy;
   logic [7:0] spi_rdata;

   modport master (
      output spi_start, spi_data, spi_dc, spi_end_txn,
      input  spi_busy, spi_rdata
   );

   modport slave (
      input  spi_start, spi_data, spi_dc, spi_end_txn,
      output spi_busy, spi_rdata
   );

endinterface

// File: rtl/spi_arb_hold_reg.sv
// One-entry request holding register with pending flag.
module spi_arb_hold_reg
   import spi_arb_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  start,
   input  logic  busy,
   input  logic  clr,
   input  hold_t din,
   output logic  pending,
   output hold_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
         q       <= '0;
      end else if (start && !busy) begin
         pending <= 1'b1;
         q       <= din;
      end else if (clr) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Two-requester SPI byte arbiter with transaction lock and hold timeout.
// SPI_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) over round-robin.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_start,
   input  logic [15:0]  req_data,
   input  logic [1:0]   req_dc,
   input  logic [1:0]   req_end,
   output logic [1:0]   req_busy,
   output logic [7:0]   rdata,
   output logic [1:0]   rdata_valid,
   spi_arb_if.master    spi,
   output logic         owner,
   output logic         locked,
   output logic         timeout_flag,
   input  logic         timeout_clr
);

   localparam int CW = $clog2(HOLD_TIMEOUT + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          first;
   logic          flush;
   hold_t         tx;
   hold_t         din  [2];
   hold_t         held [2];
   logic [1:0]    pend;
   logic [1:0]    clr;
   logic          in_flight;
   logic          done;
   logic          grant;

   assign din[0] = '{data: req_data[7:0],  dc: req_dc[0], end_txn: req_end[0]};
   assign din[1] = '{data: req_data[15:8], dc: req_dc[1], end_txn: req_end[1]};

   assign in_flight   = (state == S_ISSUE) || (state == S_RUN);
   assign locked      = (state != S_IDLE);
   assign req_busy[0] = pend[0] | (in_flight & ~owner);
   assign req_busy[1] = pend[1] | (in_flight & owner);
   assign clr[0]      = (state == S_ISSUE) & ~owner;
   assign clr[1]      = (state == S_ISSUE) & owner;
   assign done        = (state == S_RUN) & ~first & ~spi.spi_busy;

   assign spi.spi_start   = (state == S_ISSUE) || (state == S_FLUSH);
   assign spi.spi_data    = tx.data;
   assign spi.spi_dc      = tx.dc;
   assign spi.spi_end_txn = tx.end_txn;

   spi_arb_hold_reg u_hold0 (
      .clk(clk), .rst(rst), .start(req_start[0]), .busy(req_busy[0]),
      .clr(clr[0]), .din(din[0]), .pending(pend[0]), .q(held[0])
   );

   spi_arb_hold_reg u_hold1 (
      .clk(clk), .rst(rst), .start(req_start[1]), .busy(req_busy[1]),
      .clr(clr[1]), .din(din[1]), .pending(pend[1]), .q(held[1])
   );

`ifdef SPI_ARB_FIXED_PRIO_EN
   assign grant = ~pend[0];
`else
   logic last_grant;

   assign grant = (&pend) ? ~last_grant : pend[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (done && tx.end_txn) begin
         last_grant <= owner;
      end
   end
`endif

   // tx is loaded on entry to ISSUE/FLUSH so the byte bus stays put through RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         owner        <= 1'b0;
         cnt          <= '0;
         first        <= 1'b0;
         flush        <= 1'b0;
         tx           <= '0;
         rdata        <= 8'h00;
         rdata_valid  <= 2'b00;
         timeout_flag <= 1'b0;
      end else begin
         rdata_valid <= 2'b00;
         if (state == S_FLUSH) begin
            timeout_flag <= 1'b1;
         end else if (timeout_clr) begin
            timeout_flag <= 1'b0;
         end
         unique case (state)
            S_IDLE: begin
               if (|pend) begin
                  owner <= grant;
                  tx    <= held[grant];
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               first <= 1'b1;
               flush <= 1'b0;
               state <= S_RUN;
            end
            S_FLUSH: begin
               first <= 1'b1;
               flush <= 1'b1;
               state <= S_RUN;
            end
            S_RUN: begin
               first <= 1'b0;
               if (done) begin
                  if (!flush) begin
                     rdata       <= spi.spi_rdata;
                     rdata_valid <= owner ? 2'b10 : 2'b01;
                  end
                  if (tx.end_txn) begin
                     state <= S_IDLE;
                  end else begin
                     cnt   <= '0;
                     state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (pend[owner]) begin
                  tx    <= held[owner];
                  state <= S_ISSUE;
               end else if (cnt == CW'(HOLD_TIMEOUT - 1)) begin
                  tx    <= '{data: FLUSH_BYTE, dc: 1'b0, end_txn: 1'b1};
                  state <= S_FLUSH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: random transactions against a
// transaction-level model of grant order, flush and response routing.
module tb_spi_arbiter;

   typedef struct packed {
      logic [7:0] d;
      logic       dc;
      logic       e;
   } tb_byte_t;

   typedef struct packed {
      logic       o;
      logic       fl;
      logic [7:0] d;
      logic       dc;
      logic       e;
   } iss_t;

   typedef struct packed {
      logic       o;
      logic [7:0] v;
   } rv_t;

   logic        clk;
   logic        rst;
   logic [1:0]  req_start;
   logic [15:0] req_data;
   logic [1:0]  req_dc;
   logic [1:0]  req_end;
   logic [1:0]  req_busy;
   logic [7:0]  rdata;
   logic [1:0]  rdata_valid;
   logic        owner;
   logic        locked;
   logic        timeout_flag;
   logic        timeout_clr;

   logic       st  [2];
   logic [7:0] rd  [2];
   logic       dcv [2];
   logic       ev  [2];

   assign req_start = {st[1], st[0]};
   assign req_data  = {rd[1], rd[0]};
   assign req_dc    = {dcv[1], dcv[0]};
   assign req_end   = {ev[1], ev[0]};

   spi_arb_if spi ();

   spi_arbiter #(.HOLD_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .req_start(req_start), .req_data(req_data),
      .req_dc(req_dc), .req_end(req_end),
      .req_busy(req_busy), .rdata(rdata),
      .rdata_valid(rdata_valid), .spi(spi),
      .owner(owner), .locked(locked),
      .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
   );

   int nvec = 0;
   int nfail = 0;
   int cyc = 0;
   int iss_cnt = 0;
   int first_iss_cyc = 0;
   int req_cyc [2];
   int first_req = 0;

   iss_t       exp_iss_q [$];
   rv_t        exp_rv_q  [$];
   logic [7:0] rsp_q     [$];

   tb_byte_t   bq [2][4];
   int         nb [2];
   bit         ab [2];
   bit         lg;
   bit         exp_flag;
   logic [7:0] exp_rdata;
   bit         fix_en;
   logic [7:0] fix_rsp;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // SPI controller model: busy for a random time, then returns a queued byte
   initial begin
      int left;
      logic [7:0] cur;
      logic [9:0] snap;
      left = 0;
      cur = 8'h00;
      snap = '0;
      spi.spi_busy = 1'b0;
      spi.spi_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            left = 0;
            spi.spi_busy = 1'b0;
         end else if (left > 0) begin
            chk("tx_stable",
                {spi.spi_data, spi.spi_dc, spi.spi_end_txn}, snap);
            left--;
            if (left == 0) begin
               spi.spi_busy = 1'b0;
               spi.spi_rdata = cur;
            end
         end else if (spi.spi_start) begin
            snap = {spi.spi_data, spi.spi_dc, spi.spi_end_txn};
            left = $urandom_range(1, 4);
            spi.spi_busy = 1'b1;
            cur = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hEE;
         end
      end
   end

   initial begin
      iss_t e;
      forever begin
         @(negedge clk);
         if (!rst && spi.spi_start) begin
            if (iss_cnt == 0) first_iss_cyc = cyc;
            iss_cnt++;
            if (exp_iss_q.size() == 0) begin
               nvec++;
               nfail++;
               $display("FAIL issue_extra: got byte %0h, want no issue",
                        spi.spi_data);
            end else begin
               e = exp_iss_q.pop_front();
               chk("issue",
                   {owner, spi.spi_dc, spi.spi_end_txn, spi.spi_data},
                   {e.o, e.dc, e.e, e.d});
               if (e.fl) begin
                  @(negedge clk);
                  chk("tflag_set", timeout_flag, 1);
               end
            end
         end
      end
   end

   initial begin
      rv_t r;
      forever begin
         @(negedge clk);
         if (!rst && rdata_valid != 2'b00) begin
            if (exp_rv_q.size() == 0) begin
               nvec++;
               nfail++;
               $display("FAIL rv_extra: got valid %b data %0h, want none",
                        rdata_valid, rdata);
            end else begin
               r = exp_rv_q.pop_front();
               chk("rdata_valid", {rdata_valid, rdata},
                   {(r.o ? 2'b10 : 2'b01), r.v});
            end
         end
      end
   end

   // Expected issue order: whole transactions, round-robin or fixed priority
   task automatic plan(input bit p0, input bit p1);
      int ord [$];
      int i;
      logic [7:0] r;
      if (p0 && p1) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
         ord.push_back(0);
         ord.push_back(1);
`else
         ord.push_back(lg ? 0 : 1);
         ord.push_back(lg ? 1 : 0);
`endif
      end else begin
         ord.push_back(p0 ? 0 : 1);
      end
      first_req = ord[0];
      foreach (ord[j]) begin
         i = ord[j];
         for (int k = 0; k < nb[i]; k++) begin
            r = fix_en ? fix_rsp : 8'($urandom);
            exp_iss_q.push_back('{o: i[0], fl: 1'b0, d: bq[i][k].d,
                                  dc: bq[i][k].dc, e: bq[i][k].e});
            rsp_q.push_back(r);
            exp_rv_q.push_back('{o: i[0], v: r});
            exp_rdata = r;
         end
         if (ab[i]) begin
            exp_iss_q.push_back('{o: i[0], fl: 1'b1, d: 8'h00,
                                  dc: 1'b0, e: 1'b1});
            rsp_q.push_back(8'($urandom));
            exp_flag = 1'b1;
         end
         lg = i[0];
      end
   endtask

   task automatic drive(input int i);
      int n;
      for (int k = 0; k < nb[i]; k++) begin
         n = 0;
         @(negedge clk);
         while (req_busy[i] && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk("busy_wait", (n >= 300), 0);
         if (n >= 300) return;
         if (k == 0) req_cyc[i] = cyc;
         st[i]  = 1'b1;
         rd[i]  = bq[i][k].d;
         dcv[i] = bq[i][k].dc;
         ev[i]  = bq[i][k].e;
         @(negedge clk);
         st[i] = 1'b0;
      end
   endtask

   task automatic run_round(input bit p0, input bit p1, input bit clr_hold);
      int n;
      plan(p0, p1);
      iss_cnt = 0;
      timeout_clr = clr_hold;
      fork
         if (p0) drive(0);
         if (p1) drive(1);
      join
      n = 0;
      while ((exp_iss_q.size() > 0 || exp_rv_q.size() > 0 || locked)
             && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", (n >= 1000), 0);
      if (n >= 1000) begin
         exp_iss_q.delete();
         exp_rv_q.delete();
      end
      chk("latency", first_iss_cyc - req_cyc[first_req], 2);
      chk("rdata_hold", rdata, exp_rdata);
      if (clr_hold) exp_flag = 1'b0;
      timeout_clr = 1'b0;
      chk("tflag", timeout_flag, exp_flag);
      if ($urandom_range(0, 1) == 1) begin
         timeout_clr = 1'b1;
         @(negedge clk);
         timeout_clr = 1'b0;
         exp_flag = 1'b0;
         chk("tflag_clr", timeout_flag, exp_flag);
      end
   endtask

   task automatic set_byte(input int i, input int k, input logic [7:0] d,
                           input logic dc, input logic e);
      bq[i][k] = '{d: d, dc: dc, e: e};
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_busy"}, {req_busy, locked, owner}, 0);
      chk({nm, "_spi"}, {spi.spi_start, spi.spi_data,
                         spi.spi_dc, spi.spi_end_txn}, 0);
      chk({nm, "_rd"}, {rdata_valid, rdata, timeout_flag}, 0);
   endtask

   initial begin
      int n;
      int p;
      for (int i = 0; i < 2; i++) begin
         st[i] = 1'b0;
         rd[i] = 8'h00;
         dcv[i] = 1'b0;
         ev[i] = 1'b0;
         req_cyc[i] = 0;
         nb[i] = 0;
         ab[i] = 1'b0;
      end
      rst = 1'b1;
      timeout_clr = 1'b0;
      lg = 1'b1;
      exp_flag = 1'b0;
      exp_rdata = 8'h00;
      fix_en = 1'b0;
      fix_rsp = 8'h00;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      #2 rst = 1'b0;

      nb[0] = 1; nb[1] = 0;
      set_byte(0, 0, 8'hA5, 1'b0, 1'b1);
      fix_en = 1'b1;
      fix_rsp = 8'h3C;
      run_round(1, 0, 0);
      fix_en = 1'b0;

      nb[0] = 1; nb[1] = 1;
      set_byte(0, 0, 8'h11, 1'b1, 1'b1);
      set_byte(1, 0, 8'h22, 1'b0, 1'b1);
      run_round(1, 1, 0);
      run_round(1, 1, 0);
      run_round(1, 1, 0);

      nb[0] = 2; nb[1] = 1;
      set_byte(0, 0, 8'h01, 1'b0, 1'b0);
      set_byte(0, 1, 8'h02, 1'b0, 1'b1);
      set_byte(1, 0, 8'h77, 1'b1, 1'b1);
      run_round(1, 1, 0);

      nb[0] = 1; nb[1] = 0;
      set_byte(0, 0, 8'h5E, 1'b1, 1'b0);
      ab[0] = 1'b1;
      run_round(1, 0, 0);
      ab[0] = 1'b0;

      nb[0] = 1; nb[1] = 0;
      set_byte(0, 0, 8'h5A, 1'b1, 1'b1);
      plan(1, 0);
      iss_cnt = 0;
      fork
         drive(0);
      join_none
      n = 0;
      while (iss_cnt == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mid_issue_seen", (n >= 50), 0);
      #1 rst = 1'b1;
      #1 check_all_zero("mid_rst");
      exp_iss_q.delete();
      exp_rv_q.delete();
      rsp_q.delete();
      lg = 1'b1;
      exp_flag = 1'b0;
      exp_rdata = 8'h00;
      @(negedge clk);
      #2 rst = 1'b0;
      set_byte(0, 0, 8'hC3, 1'b0, 1'b1);
      run_round(1, 0, 0);

      for (int r = 0; r < 40; r++) begin
         p = $urandom_range(1, 3);
         for (int i = 0; i < 2; i++) begin
            nb[i] = $urandom_range(1, 3);
            ab[i] = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < nb[i]; k++) begin
               set_byte(i, k, 8'($urandom), 1'($urandom),
                        (k == nb[i] - 1) && !ab[i]);
            end
         end
         run_round(p[0], p[1], ($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

endmodule
